regfile_write_arbiter: RTL

- Shares the single write port (WRITE, INADDRESS, IN) of the 8x8-bit register file between two write-back sources: A (ALU result) and B (data-memory load).
- Each source has a 1-entry holding buffer. Buffered writes are committed oldest-first, so writes to the same register land in acceptance order.
- Exports a per-register pending-write scoreboard (BUSY) for hazard detection in the control unit.

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between an ALU (A) and a load (B) source.
// Each source owns a 1-entry buffer; buffered writes commit oldest-first.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned NREG   = 2 ** ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              A_VALID,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_DATA,
   output logic              A_READY,
   input  logic              B_VALID,
   input  logic [ADDR_W-1:0] B_ADDR,
   input  logic [DATA_W-1:0] B_DATA,
   output logic              B_READY,
   input  logic              HOLD,
   output logic              WRITE,
   output logic [ADDR_W-1:0] INADDRESS,
   output logic [DATA_W-1:0] IN,
   output logic [NREG-1:0]   BUSY
);

   logic              a_full_q, a_full_d;
   logic              b_full_q, b_full_d;
   logic [ADDR_W-1:0] a_addr_q, a_addr_d;
   logic [ADDR_W-1:0] b_addr_q, b_addr_d;
   logic [DATA_W-1:0] a_data_q, a_data_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic              a_older_q, a_older_d;

   logic a_win, b_win;
   logic a_load, b_load;
   logic a_stays, b_stays;

   always_comb begin
      a_win = 1'b0;
      b_win = 1'b0;
      if (!RESET && !HOLD) begin
         a_win = a_full_q && (!b_full_q || a_older_q);
         b_win = b_full_q && (!a_full_q || !a_older_q);
      end

      WRITE     = a_win || b_win;
      INADDRESS = '0;
      IN        = '0;
      if (a_win) begin
         INADDRESS = a_addr_q;
         IN        = a_data_q;
      end else if (b_win) begin
         INADDRESS = b_addr_q;
         IN        = b_data_q;
      end

      // A draining entry may be refilled on the same edge.
      A_READY = RESET || !a_full_q || a_win;
      B_READY = RESET || !b_full_q || b_win;

      a_load  = A_VALID && A_READY && !RESET;
      b_load  = B_VALID && B_READY && !RESET;
      a_stays = a_full_q && !a_win;
      b_stays = b_full_q && !b_win;

      a_full_d = a_load || a_stays;
      b_full_d = b_load || b_stays;
      a_addr_d = a_load ? A_ADDR : a_addr_q;
      a_data_d = a_load ? A_DATA : a_data_q;
      b_addr_d = b_load ? B_ADDR : b_addr_q;
      b_data_d = b_load ? B_DATA : b_data_q;

      // Age tracks acceptance order; a simultaneous load treats A as older.
      a_older_d = a_older_q;
      if (a_load && b_load)        a_older_d = 1'b1;
      else if (a_load && b_stays)  a_older_d = 1'b0;
      else if (b_load && a_stays)  a_older_d = 1'b1;

      BUSY = '0;
      if (!RESET) begin
         for (int r = 0; r < NREG; r++) begin
            BUSY[r] = (a_full_q && (a_addr_q == ADDR_W'(r))) ||
                      (b_full_q && (b_addr_q == ADDR_W'(r)));
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         a_full_q  <= 1'b0;
         b_full_q  <= 1'b0;
         a_older_q <= 1'b1;
      end else begin
         a_full_q  <= a_full_d;
         b_full_q  <= b_full_d;
         a_older_q <= a_older_d;
      end
      a_addr_q <= a_addr_d;
      a_data_q <= a_data_d;
      b_addr_q <= b_addr_d;
      b_data_q <= b_data_d;
   end

endmodule
